// File: rtl/bcd_step_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of a synchronised slow level.
// Optional multiplexed seven-segment drive is built when BCD_STEP_COUNTER_SEVSEG_EN is defined.
module bcd_step_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 1) begin : g_bad_params
        $error("bcd_step_counter: DIGITS must be 1..8 and SCAN_DIV at least 1");
    end

    logic                s1_q, s2_q, s3_q;
    logic                step_pulse;
    state_t              state_q, state_d;
    logic                running_q, running_d;
    logic                wrap_q, wrap_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] stepped;
    logic                step_carry;
    logic                count_en;

    // s3 holds the previous synchronised level so only rising edges produce a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= step_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign step_pulse = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && state_q != ST_RUN) begin
            state_d = ST_RUN;
        end
        running_d = (state_d == ST_RUN);
    end

    assign count_en = (state_q == ST_RUN) && step_pulse && !clear && !stop;

    // Carry/borrow ripples from digit 0 upward; a carry out of the top digit is a wrap
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        carry   = 1'b1;
        digit   = 4'd0;
        stepped = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd_q[4*i +: 4];
            if (carry) begin
                if (dir) begin
                    if (digit == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digit - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        step_carry = carry;
    end

    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (count_en) begin
            bcd_d  = stepped;
            wrap_d = step_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bcd     = bcd_q;
    assign running = running_q;
    assign wrap    = wrap_q;

`ifdef BCD_STEP_COUNTER_SEVSEG_EN
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [3:0]        shown;

    // seg and an are both derived from the next index so they change on the same edge
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        an_d        = '1;
        an_d[idx_d] = 1'b0;
        shown       = bcd_q[4*idx_d +: 4];
        case (shown)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= 7'h7F;
            an_q   <= '1;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
`else
    assign seg = 7'h7F;
    assign an  = '1;
`endif

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter: directed scenarios plus randomized control/step traffic
// compared every cycle against an arithmetic model of the counter.
module tb_bcd_step_counter;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int MOD      = 10000;
   localparam int IDLE_S   = 0;
   localparam int RUN_S    = 1;
   localparam int PAUSE_S  = 2;

   logic        clk;
   logic        rst_n;
   logic        step_in;
   logic        start;
   logic        stop;
   logic        clear;
   logic        dir;
   logic [15:0] bcd;
   logic        running;
   logic        wrap;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checkCount;
   int passCount;
   int wrapCount;

   int         mCount;
   int         mState;
   logic       mWrap;
   logic [2:0] mHist;
   int         mEdges;
   logic [6:0] mSeg;
   logic [3:0] mAn;

   bcd_step_counter #(
      .DIGITS  (DIGITS),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_in(step_in),
      .start  (start),
      .stop   (stop),
      .clear  (clear),
      .dir    (dir),
      .bcd    (bcd),
      .running(running),
      .wrap   (wrap),
      .seg    (seg),
      .an     (an)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] toBcd(input int value);
      logic [15:0] r;
      int v;
      v = value;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int digitOf(input int value, input int pos);
      int v;
      v = value;
      for (int i = 0; i < pos; i++) v = v / 10;
      return v % 10;
   endfunction

   function automatic logic [6:0] segPattern(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle's worth of inputs on the falling edge, holding them until the next call
   task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic si, input logic dv);
      @(negedge clk);
      start   = st;
      stop    = sp;
      clear   = cl;
      step_in = si;
      dir     = dv;
   endtask

   task automatic stepMany(input int n, input logic dv);
      for (int s = 0; s < n; s++) begin
         for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, dv);
         for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, dv);
      end
   endtask

   task automatic pulseCtrl(input logic st, input logic sp, input logic cl);
      applyStimulus(st, sp, cl, 1'b0, dir);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, dir);
   endtask

   // Reference model: the count is a plain integer modulo 10^DIGITS; a step is a 0->1 of the
   // input level as seen two and three edges earlier
   always @(posedge clk or negedge rst_n) begin : refModel
      int   nCount;
      int   nState;
      int   idx;
      logic nWrap;
      logic pulse;
      if (!rst_n) begin
         mCount <= 0;
         mState <= IDLE_S;
         mWrap  <= 1'b0;
         mHist  <= 3'b000;
         mEdges <= 0;
         mSeg   <= 7'h7F;
         mAn    <= 4'hF;
      end else begin
         pulse  = mHist[1] & ~mHist[2];
         nCount = mCount;
         nState = mState;
         nWrap  = 1'b0;
         if (clear) begin
            nCount = 0;
            nState = IDLE_S;
         end else begin
            if (mState == RUN_S && pulse && !stop) begin
               if (dir) begin
                  nWrap  = (mCount == MOD - 1);
                  nCount = (mCount + 1) % MOD;
               end else begin
                  nWrap  = (mCount == 0);
                  nCount = (mCount + MOD - 1) % MOD;
               end
            end
            if (stop) begin
               if (mState == RUN_S) nState = PAUSE_S;
            end else if (start && mState != RUN_S) begin
               nState = RUN_S;
            end
         end
         idx = ((mEdges + 1) / SCAN_DIV) % DIGITS;
`ifdef BCD_STEP_COUNTER_SEVSEG_EN
         mAn  <= ~(4'b0001 << idx);
         mSeg <= segPattern(digitOf(mCount, idx));
`else
         mAn  <= 4'hF;
         mSeg <= 7'h7F;
`endif
         mHist  <= {mHist[1:0], step_in};
         mEdges <= mEdges + 1;
         mCount <= nCount;
         mState <= nState;
         mWrap  <= nWrap;
      end
   end

   // Every cycle out of reset, all outputs must agree with the model
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("cyc_bcd", 32'(bcd), 32'(toBcd(mCount)));
         checkOutput("cyc_running", 32'(running), 32'(mState == RUN_S));
         checkOutput("cyc_wrap", 32'(wrap), 32'(mWrap));
         checkOutput("cyc_seg", 32'(seg), 32'(mSeg));
         checkOutput("cyc_an", 32'(an), 32'(mAn));
      end
   end

   always @(negedge clk) begin
      if (rst_n && wrap === 1'b1) wrapCount++;
   end

   initial begin : mainSeq
      int wrapBase;
      int anHits[4];
      logic [6:0] expSeg;
      int level;
      int dur;
      int r;
      logic dv;

      checkCount = 0;
      passCount  = 0;
      rst_n   = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      clear   = 1'b0;
      step_in = 1'b0;
      dir     = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_bcd", 32'(bcd), 32'h0);
      checkOutput("rst_running", 32'(running), 32'h0);
      checkOutput("rst_wrap", 32'(wrap), 32'h0);
      checkOutput("rst_seg", 32'(seg), 32'h7F);
      checkOutput("rst_an", 32'(an), 32'hF);
      rst_n = 1'b1;

      // Twelve up-steps from reset
      pulseCtrl(1'b1, 1'b0, 1'b0);
      stepMany(12, 1'b1);
      checkOutput("up12_bcd", 32'(bcd), 32'h0012);
      checkOutput("up12_model", 32'(toBcd(mCount)), 32'h0012);
      checkOutput("up12_running", 32'(running), 32'h1);

      // Increment lands on the third edge after step_in rises
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("lat_before", 32'(bcd), 32'h0012);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("lat_after", 32'(bcd), 32'h0013);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Preload 9998 by stepping down through zero, then wrap upward
      pulseCtrl(1'b0, 1'b0, 1'b1);
      pulseCtrl(1'b1, 1'b0, 1'b0);
      wrapBase = wrapCount;
      stepMany(1, 1'b0);
      checkOutput("down_wrap_bcd", 32'(bcd), 32'h9999);
      checkOutput("down_wrap_cnt", 32'(wrapCount - wrapBase), 32'd1);
      stepMany(1, 1'b0);
      checkOutput("preload_bcd", 32'(bcd), 32'h9998);
      wrapBase = wrapCount;
      stepMany(1, 1'b1);
      checkOutput("up_9999", 32'(bcd), 32'h9999);
      stepMany(1, 1'b1);
      checkOutput("up_wrap_bcd", 32'(bcd), 32'h0000);
      checkOutput("up_wrap_cnt", 32'(wrapCount - wrapBase), 32'd1);
      wrapBase = wrapCount;
      stepMany(1, 1'b0);
      checkOutput("down2_wrap_bcd", 32'(bcd), 32'h9999);
      stepMany(1, 1'b0);
      checkOutput("down2_bcd", 32'(bcd), 32'h9998);
      checkOutput("down2_wrap_cnt", 32'(wrapCount - wrapBase), 32'd1);

      // Pause holds the count; resume coincident with a step does not count that step
      pulseCtrl(1'b0, 1'b0, 1'b1);
      pulseCtrl(1'b1, 1'b0, 1'b0);
      stepMany(5, 1'b1);
      checkOutput("pre_pause_bcd", 32'(bcd), 32'h0005);
      pulseCtrl(1'b0, 1'b1, 1'b0);
      stepMany(3, 1'b1);
      checkOutput("pause_bcd", 32'(bcd), 32'h0005);
      checkOutput("pause_running", 32'(running), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("resume_bcd", 32'(bcd), 32'h0005);
      checkOutput("resume_running", 32'(running), 32'h1);
      stepMany(1, 1'b1);
      checkOutput("resume_step_bcd", 32'(bcd), 32'h0006);

      // clear+stop+start together at 0042
      pulseCtrl(1'b0, 1'b0, 1'b1);
      pulseCtrl(1'b1, 1'b0, 1'b0);
      stepMany(42, 1'b1);
      checkOutput("cnt42_bcd", 32'(bcd), 32'h0042);
      wrapBase = wrapCount;
      pulseCtrl(1'b1, 1'b1, 1'b1);
      checkOutput("combo_bcd", 32'(bcd), 32'h0);
      checkOutput("combo_running", 32'(running), 32'h0);
      checkOutput("combo_model_state", 32'(mState), 32'(IDLE_S));
      checkOutput("combo_wrap_cnt", 32'(wrapCount - wrapBase), 32'd0);

      // Asynchronous reset mid-count, observed before any further clock edge
      pulseCtrl(1'b1, 1'b0, 1'b0);
      stepMany(3, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_bcd", 32'(bcd), 32'h0);
      checkOutput("async_running", 32'(running), 32'h0);
      checkOutput("async_wrap", 32'(wrap), 32'h0);
      checkOutput("async_seg", 32'(seg), 32'h7F);
      checkOutput("async_an", 32'(an), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef BCD_STEP_COUNTER_SEVSEG_EN
      // Display scan of 1234
      pulseCtrl(1'b1, 1'b0, 1'b0);
      stepMany(1234, 1'b1);
      pulseCtrl(1'b0, 1'b1, 1'b0);
      checkOutput("scan_bcd", 32'(bcd), 32'h1234);
      for (int k = 0; k < 4; k++) anHits[k] = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         case (an)
            4'b1110: begin expSeg = 7'h19; anHits[0]++; end
            4'b1101: begin expSeg = 7'h30; anHits[1]++; end
            4'b1011: begin expSeg = 7'h24; anHits[2]++; end
            4'b0111: begin expSeg = 7'h79; anHits[3]++; end
            default: expSeg = 7'h7F;
         endcase
         checkOutput("scan_seg", 32'(seg), 32'(expSeg));
      end
      for (int k = 0; k < 4; k++) checkOutput("scan_an_hits", 32'(anHits[k]), 32'd4);
`endif

      // Randomized control and step traffic
      pulseCtrl(1'b0, 1'b0, 1'b1);
      pulseCtrl(1'b1, 1'b0, 1'b0);
      level = 0;
      for (int seg_i = 0; seg_i < 80; seg_i++) begin
         level = 1 - level;
         dur = int'($urandom_range(2, 6));
         for (int c = 0; c < dur; c++) begin
            r  = int'($urandom_range(0, 15));
            dv = 1'($urandom_range(0, 1));
            applyStimulus(r == 0, r == 1, (r == 2) && ($urandom_range(0, 3) == 0), level[0], dv);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
